winograd_conv_tiled: RTL

WINOGRAD_CONV_TILED -- requirements
Module: winograd_conv_tiled

---
 rtl/winograd_pkg.sv | 29 ++
 rtl/winograd_tile_f2x3.sv | 121 ++++++++++++
 rtl/winograd_conv_tiled.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and types for the tiled Winograd F(2x2,3x3) convolver.
//   BT : input transform B^T (4x4)
//   G2 : kernel transform scaled by two, 2G (4x3), so all coefficients are integers
//   AT : output transform A^T (2x4)
//   state_e : tile sequencer states
package winograd_pkg;

  localparam int BT [4][4] = '{'{1,  0, -1,  0},
                               '{0,  1,  1,  0},
                               '{0, -1,  1,  0},
                               '{0,  1,  0, -1}};

  localparam int G2 [4][3] = '{'{2,  0, 0},
                               '{1,  1, 1},
                               '{1, -1, 1},
                               '{0,  0, 2}};

  localparam int AT [2][4] = '{'{1, 1,  1,  0},
                               '{0, 1, -1, -1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_KXFORM,
    S_TILE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/winograd_tile_f2x3.sv
// One Winograd F(2x2,3x3) tile engine, two pipeline stages.
//   stage 1: V = B^T d B of the 4x4 window, registered with tile coordinates
//   stage 2: M = V .* U, Y4 = A^T M A, Y = Y4 >>> 2; presented to the caller,
//            which writes it into the result array on the following edge
// Ports:
//   clk, rst_n        clock, async active-low reset
//   issue_i           a tile window is presented this cycle
//   tr_i, tc_i        tile row / column of the presented window
//   win_i             4x4 input window (DATA_W signed elements)
//   u_i               transformed kernel U = (2G)K(2G)^T, DATA_W+2 bits
//   res_vld_o         stage-2 result valid
//   res_tr_o/tc_o     tile coordinates belonging to res_o
//   res_o             2x2 output tile, truncated to DATA_W
module winograd_tile_f2x3 import winograd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RW     = 4,
  parameter int CW     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_i,
  input  logic [RW-1:0]                    tr_i,
  input  logic [CW-1:0]                    tc_i,
  input  logic [3:0][3:0][DATA_W-1:0]      win_i,
  input  logic [3:0][3:0][DATA_W+1:0]      u_i,
  output logic                             res_vld_o,
  output logic [RW-1:0]                    res_tr_o,
  output logic [CW-1:0]                    res_tc_o,
  output logic [1:0][1:0][DATA_W-1:0]      res_o
);
  // All arithmetic is modulo 2^XW; since U carries a factor of 4, Y4 is
  // exactly 4*y mod 2^XW and the low DATA_W bits after >>>2 equal y mod 2^DATA_W.
  localparam int XW     = DATA_W + 2;
  localparam int STAGES = 1;

  function automatic logic [XW-1:0] sx(input logic [DATA_W-1:0] x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  logic [STAGES:1]             vld_q;
  logic [STAGES:0]             vld_pipe;
  logic [3:0][3:0][XW-1:0]     t, v_d, v_q;
  logic [3:0][3:0][XW-1:0]     m;
  logic [1:0][3:0][XW-1:0]     s;
  logic [RW-1:0]               tr_q;
  logic [CW-1:0]               tc_q;

  assign vld_pipe = {vld_q, issue_i};

  // stage 1: input transform
  always_comb begin
    logic [XW-1:0] acc;
    acc = '0;
    t   = '0;
    v_d = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + XW'(BT[i][k]) * sx(win_i[k][j]);
        t[i][j] = acc;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + t[i][k] * XW'(BT[j][k]);
        v_d[i][j] = acc;
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      v_q   <= '0;
      tr_q  <= '0;
      tc_q  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (issue_i) begin
        v_q  <= v_d;
        tr_q <= tr_i;
        tc_q <= tc_i;
      end
    end
  end

  // stage 2: element-wise multiply, output transform, divide by 4
  always_comb begin
    logic [XW-1:0]        acc;
    logic signed [XW-1:0] y_sh;
    acc   = '0;
    y_sh  = '0;
    m     = '0;
    s     = '0;
    res_o = '0;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++)
        m[k][l] = v_q[k][l] * u_i[k][l];
    for (int i = 0; i < 2; i++)
      for (int l = 0; l < 4; l++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + XW'(AT[i][k]) * m[k][l];
        s[i][l] = acc;
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = '0;
        for (int l = 0; l < 4; l++)
          acc = acc + s[i][l] * XW'(AT[j][l]);
        y_sh        = $signed(acc) >>> 2;
        res_o[i][j] = y_sh[DATA_W-1:0];
      end
  end

  assign res_vld_o = vld_q[STAGES];
  assign res_tr_o  = tr_q;
  assign res_tc_o  = tc_q;

endmodule

// File: rtl/winograd_conv_tiled.sv
// Tiled 3x3 valid-mode convolution using Winograd F(2x2,3x3).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle request; ignored while busy
//   image_in     IMG_H x IMG_W image, held stable by the caller for the run
//   kernel_in    3x3 kernel, captured on the accepting edge
//   result_out   (IMG_H-2) x (IMG_W-2) registered result, updated tile by tile
//   busy         high from the accepting edge until done drops
//   done         one-cycle completion pulse
module winograd_conv_tiled import winograd_pkg::*; #(
  parameter int IMG_H  = 10,
  parameter int IMG_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [IMG_H-1:0][IMG_W-1:0][DATA_W-1:0]  image_in,
  input  logic [2:0][2:0][DATA_W-1:0]              kernel_in,
  output logic [IMG_H-3:0][IMG_W-3:0][DATA_W-1:0]  result_out,
  output logic                                     busy,
  output logic                                     done
);
  if ((IMG_H % 2) != 0 || IMG_H < 4) begin : g_bad_h
    $error("IMG_H must be even and >= 4");
  end
  if ((IMG_W % 2) != 0 || IMG_W < 4) begin : g_bad_w
    $error("IMG_W must be even and >= 4");
  end

  localparam int XW      = DATA_W + 2;
  localparam int RW      = $clog2(IMG_H);
  localparam int CW      = $clog2(IMG_W);
  localparam int TR_LAST = (IMG_H - 2) / 2 - 1;
  localparam int TC_LAST = (IMG_W - 2) / 2 - 1;

  function automatic logic [XW-1:0] sx(input logic [DATA_W-1:0] x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  state_e                              state_q, state_d;
  logic [2:0][2:0][DATA_W-1:0]         k_q;
  logic [3:0][3:0][XW-1:0]             u_q, u_d;
  logic [3:0][2:0][XW-1:0]             gk;
  logic [RW-1:0]                       tr_q, tr_d;
  logic [CW-1:0]                       tc_q, tc_d;
  logic                                drain_q, drain_d;
  logic                                k_ld, u_ld, issue;
  logic [3:0][3:0][DATA_W-1:0]         win;
  logic [IMG_H-3:0][IMG_W-3:0][DATA_W-1:0] result_q;
  logic                                res_vld;
  logic [RW-1:0]                       res_tr;
  logic [CW-1:0]                       res_tc;
  logic [1:0][1:0][DATA_W-1:0]         res;

  // U = (2G) K (2G)^T from the captured kernel
  always_comb begin
    logic [XW-1:0] acc;
    acc = '0;
    gk  = '0;
    u_d = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) begin
        acc = '0;
        for (int k = 0; k < 3; k++)
          acc = acc + XW'(G2[i][k]) * sx(k_q[k][j]);
        gk[i][j] = acc;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 3; k++)
          acc = acc + gk[i][k] * XW'(G2[j][k]);
        u_d[i][j] = acc;
      end
  end

  // 4x4 window at (2*tr, 2*tc); the last tile ends exactly on the last row/column
  always_comb begin
    logic [RW-1:0] ri;
    logic [CW-1:0] ci;
    ri  = '0;
    ci  = '0;
    win = '0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        ri = tr_q + tr_q + RW'(a);
        ci = tc_q + tc_q + CW'(b);
        win[a][b] = image_in[ri][ci];
      end
  end

  always_comb begin
    state_d = state_q;
    tr_d    = tr_q;
    tc_d    = tc_q;
    drain_d = 1'b0;
    k_ld    = 1'b0;
    u_ld    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        k_ld    = 1'b1;
        state_d = S_KXFORM;
      end
      S_KXFORM: begin
        u_ld    = 1'b1;
        tr_d    = '0;
        tc_d    = '0;
        state_d = S_TILE;
      end
      S_TILE: begin
        issue = 1'b1;
        if (tc_q == CW'(TC_LAST)) begin
          tc_d = '0;
          if (tr_q == RW'(TR_LAST)) state_d = S_DRAIN;
          else                      tr_d    = tr_q + RW'(1);
        end else begin
          tc_d = tc_q + CW'(1);
        end
      end
      // two cycles so the last tile has landed in result_out before done
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      u_q     <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      drain_q <= drain_d;
      if (k_ld) k_q <= kernel_in;
      if (u_ld) u_q <= u_d;
    end
  end

  winograd_tile_f2x3 #(
    .DATA_W (DATA_W),
    .RW     (RW),
    .CW     (CW)
  ) u_tile (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (issue),
    .tr_i      (tr_q),
    .tc_i      (tc_q),
    .win_i     (win),
    .u_i       (u_q),
    .res_vld_o (res_vld),
    .res_tr_o  (res_tr),
    .res_tc_o  (res_tc),
    .res_o     (res)
  );

  // Only the 2x2 block addressed by the returning tile is written; the rest holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (res_vld) begin
      for (int r = 0; r < IMG_H - 2; r++)
        for (int c = 0; c < IMG_W - 2; c++)
          if (res_tr == RW'(r / 2) && res_tc == CW'(c / 2))
            result_q[r][c] <= res[r % 2][c % 2];
    end
  end

  assign result_out = result_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
